main_control_fsm: RTL and testbench

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/main_control_fsm.sv | 161 ++++++++++++++++
 tb/tb_main_control_fsm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/main_control_fsm.sv
// Multicycle RISC-V main control FSM (Moore).
// Sequences fetch/decode/execute/memory/writeback and drives datapath selects.
// Outputs are forced low combinationally while reset is held.
module main_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       memReady,
  output logic       memReq,
  output logic       memWrite,
  output logic       irWrite,
  output logic       adrSrc,
  output logic       pcWrite,
  output logic       regWrite,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] resultSrc,
  output logic [1:0] immSrc,
  output logic       illegalInstr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t cur, nxt;

  // State register; reset lands in FETCH immediately, no clock needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= FETCH;
    else        cur <= nxt;
  end

  // Next-state: memReady only matters in the three memory-handshake states.
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:    nxt = memReady ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXECUTER;
          OP_I:         nxt = EXECUTEI;
          OP_JAL:       nxt = JAL;
          OP_BEQ:       nxt = BEQ;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:   nxt = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  nxt = memReady ? MEMWB : MEMREAD;
      MEMWRITE: nxt = memReady ? FETCH : MEMWRITE;
      EXECUTER: nxt = ALUWB;
      EXECUTEI: nxt = ALUWB;
      JAL:      nxt = ALUWB;
      MEMWB:    nxt = FETCH;
      ALUWB:    nxt = FETCH;
      BEQ:      nxt = FETCH;
      default:  nxt = FETCH;
    endcase
  end

  // Output decode; unused codes leave every strobe at its zero default.
  always_comb begin
    memReq       = 1'b0;
    memWrite     = 1'b0;
    irWrite      = 1'b0;
    adrSrc       = 1'b0;
    pcWrite      = 1'b0;
    regWrite     = 1'b0;
    aluSrcA      = 2'b00;
    aluSrcB      = 2'b00;
    aluOp        = 2'b00;
    resultSrc    = 2'b00;
    immSrc       = 2'b00;
    illegalInstr = 1'b0;
    if (rst_n) begin
      case (op)
        OP_SW:   immSrc = 2'b01;
        OP_BEQ:  immSrc = 2'b10;
        OP_JAL:  immSrc = 2'b11;
        default: immSrc = 2'b00;
      endcase
      case (cur)
        FETCH: begin
          memReq    = 1'b1;
          aluSrcB   = 2'b10;
          resultSrc = 2'b10;
          irWrite   = memReady;
          pcWrite   = memReady;
        end
        DECODE: begin
          aluSrcA = 2'b01;
          aluSrcB = 2'b01;
          illegalInstr = !(op == OP_LW || op == OP_SW || op == OP_R ||
                           op == OP_I  || op == OP_BEQ || op == OP_JAL);
        end
        MEMADR: begin
          aluSrcA = 2'b10;
          aluSrcB = 2'b01;
        end
        MEMREAD: begin
          memReq = 1'b1;
          adrSrc = 1'b1;
        end
        MEMWRITE: begin
          memReq   = 1'b1;
          adrSrc   = 1'b1;
          memWrite = 1'b1;
        end
        EXECUTER: begin
          aluSrcA = 2'b10;
          aluOp   = 2'b10;
        end
        EXECUTEI: begin
          aluSrcA = 2'b10;
          aluSrcB = 2'b01;
          aluOp   = 2'b10;
        end
        MEMWB: begin
          resultSrc = 2'b01;
          regWrite  = 1'b1;
        end
        ALUWB:    regWrite = 1'b1;
        JAL: begin
          aluSrcA = 2'b01;
          aluSrcB = 2'b10;
          pcWrite = 1'b1;
        end
        BEQ: begin
          aluSrcA = 2'b10;
          aluOp   = 2'b01;
          pcWrite = zero;
        end
        default: ;
      endcase
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench for main_control_fsm: each scenario queues the expected
// per-cycle state plus output word, then drains it against the DUT.
module tb_main_control_fsm;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       memReady;
  logic       memReq, memWrite, irWrite, adrSrc, pcWrite, regWrite, illegalInstr;
  logic [1:0] aluSrcA, aluSrcB, aluOp, resultSrc, immSrc;
  logic [3:0] state;

  main_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .memReady(memReady),
    .memReq(memReq), .memWrite(memWrite), .irWrite(irWrite), .adrSrc(adrSrc),
    .pcWrite(pcWrite), .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluOp(aluOp), .resultSrc(resultSrc), .immSrc(immSrc),
    .illegalInstr(illegalInstr), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  // {memReq,memWrite,irWrite,adrSrc,pcWrite,regWrite,aluSrcA,aluSrcB,aluOp,resultSrc,immSrc,illegalInstr}
  logic [16:0] outs;
  assign outs = {memReq, memWrite, irWrite, adrSrc, pcWrite, regWrite,
                 aluSrcA, aluSrcB, aluOp, resultSrc, immSrc, illegalInstr};

  typedef struct {
    logic [3:0]  st;
    logic        rdy;
    logic [16:0] o;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc;

  // Reference output table, written from the per-state control listing.
  function automatic logic [16:0] model(input logic [3:0] st, input logic [6:0] o,
                                        input logic z, input logic rdy);
    logic mr, mw, ir, ad, pw, rw, il;
    logic [1:0] a, b, alu, rs, im;
    {mr, mw, ir, ad, pw, rw, il} = '0;
    {a, b, alu, rs} = '0;
    im = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
    case (st)
      4'd0:  begin mr = 1; b = 2'b10; rs = 2'b10; ir = rdy; pw = rdy; end
      4'd1:  begin a = 2'b01; b = 2'b01;
                   il = !(o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL); end
      4'd2:  begin a = 2'b10; b = 2'b01; end
      4'd3:  begin mr = 1; ad = 1; end
      4'd4:  begin rs = 2'b01; rw = 1; end
      4'd5:  begin mr = 1; ad = 1; mw = 1; end
      4'd6:  begin a = 2'b10; alu = 2'b10; end
      4'd7:  rw = 1;
      4'd8:  begin a = 2'b10; b = 2'b01; alu = 2'b10; end
      4'd9:  begin a = 2'b01; b = 2'b10; pw = 1; end
      4'd10: begin a = 2'b10; alu = 2'b01; pw = z; end
      default: ;
    endcase
    return {mr, mw, ir, ad, pw, rw, a, b, alu, rs, im, il};
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy);
    exp_t x;
    x.st = st; x.rdy = rdy; x.o = model(st, op, zero, rdy);
    sb.push_back(x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op = LW; zero = 1'b0; memReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({state, outs} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset: got st=%0d outs=%h, want st=0 outs=0", state, outs);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    op = LW;
    push(0, 1); push(1, 1); push(2, 1); push(3, 1); push(4, 1); push(0, 0);
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); memReady = e.rdy; @(negedge clk); vectors++; cyc++;
      if ({state, outs} !== {e.st, e.o}) begin
        miscompares++;
        $display("FAIL lw c%0d: got st=%0d outs=%h, want st=%0d outs=%h", cyc, state, outs, e.st, e.o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    op = SW;
    push(0, 1); push(1, 1); push(2, 1); push(5, 1); push(0, 0);
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); memReady = e.rdy; @(negedge clk); vectors++; cyc++;
      if ({state, outs} !== {e.st, e.o}) begin
        miscompares++;
        $display("FAIL sw c%0d: got st=%0d outs=%h, want st=%0d outs=%h", cyc, state, outs, e.st, e.o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq(input logic z);
    op = BQ; zero = z;
    push(0, 1); push(1, 1); push(10, 1); push(0, 0);
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); memReady = e.rdy; @(negedge clk); vectors++; cyc++;
      if ({state, outs} !== {e.st, e.o}) begin
        miscompares++;
        $display("FAIL beq z=%0b c%0d: got st=%0d outs=%h, want st=%0d outs=%h", z, cyc, state, outs, e.st, e.o);
      end
      @(posedge clk); #1;
    end
    zero = 1'b0;
  endtask

  task automatic test_stall_rtype();
    op = RT;
    push(0, 0); push(0, 0); push(0, 0); push(0, 1);
    push(1, 1); push(6, 1); push(7, 1); push(0, 0);
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); memReady = e.rdy; @(negedge clk); vectors++; cyc++;
      if ({state, outs} !== {e.st, e.o}) begin
        miscompares++;
        $display("FAIL stall c%0d: got st=%0d outs=%h, want st=%0d outs=%h", cyc, state, outs, e.st, e.o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_itype_jal();
    op = IT;
    push(0, 1); push(1, 1); push(8, 1); push(7, 1); push(0, 0);
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); memReady = e.rdy; @(negedge clk); vectors++; cyc++;
      if ({state, outs} !== {e.st, e.o}) begin
        miscompares++;
        $display("FAIL itype c%0d: got st=%0d outs=%h, want st=%0d outs=%h", cyc, state, outs, e.st, e.o);
      end
      @(posedge clk); #1;
    end
    op = JL;
    push(0, 1); push(1, 1); push(9, 1); push(7, 1); push(0, 0);
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); memReady = e.rdy; @(negedge clk); vectors++; cyc++;
      if ({state, outs} !== {e.st, e.o}) begin
        miscompares++;
        $display("FAIL jal c%0d: got st=%0d outs=%h, want st=%0d outs=%h", cyc, state, outs, e.st, e.o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    op = BAD;
    push(0, 1); push(1, 1); push(0, 0);
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); memReady = e.rdy; @(negedge clk); vectors++; cyc++;
      if ({state, outs} !== {e.st, e.o}) begin
        miscompares++;
        $display("FAIL illegal c%0d: got st=%0d outs=%h, want st=%0d outs=%h", cyc, state, outs, e.st, e.o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midop();
    op = LW;
    push(0, 1); push(1, 1); push(2, 1); push(3, 1); push(4, 1);
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); memReady = e.rdy; @(negedge clk); vectors++; cyc++;
      if ({state, outs} !== {e.st, e.o}) begin
        miscompares++;
        $display("FAIL midrst c%0d: got st=%0d outs=%h, want st=%0d outs=%h", cyc, state, outs, e.st, e.o);
      end
      if (sb.size() > 0) begin @(posedge clk); #1; end
    end
    // Now mid-cycle in MEMWB with regWrite high: pull reset between edges.
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({state, outs} !== 21'd0) begin
      miscompares++;
      $display("FAIL async rst: got st=%0d outs=%h, want st=0 outs=0", state, outs);
    end
    @(posedge clk); #1;
    vectors++;
    if ({state, regWrite, memWrite, pcWrite} !== 7'd0) begin
      miscompares++;
      $display("FAIL rst held: got st=%0d rw=%0b mw=%0b pw=%0b, want all 0", state, regWrite, memWrite, pcWrite);
    end
    rst_n = 1'b1;
    op = RT;
    push(0, 1); push(1, 1); push(6, 1); push(7, 1); push(0, 0);
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); memReady = e.rdy; @(negedge clk); vectors++; cyc++;
      if ({state, outs} !== {e.st, e.o}) begin
        miscompares++;
        $display("FAIL post-rst rtype c%0d: got st=%0d outs=%h, want st=%0d outs=%h", cyc, state, outs, e.st, e.o);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_stall_rtype();
    test_itype_jal();
    test_illegal();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
